control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Moore FSM that drives the datapath's control inputs: one-hot register in/out strobes, PC/MAR/MDR/IR/Y/Z/HI/LO strobes, ALU opcode.
//  Performs fetch (with a memory-ready handshake), decode and execute.
//  Covers register-register ALU, unary and mul/div instructions.
//  Sits directly upstream of the datapath; its ir input is the datapath IR register output.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for mem_ready in T1 (used only when CS_MEM_TIMEOUT_EN is defined)
// PORTS
//  clock        in   1   system clock, all state changes on rising edge
//  clear        in   1   reset, synchronous, active-low
//  run          in   1   high: start/continue instruction execution
//  ir           in   32  IR contents; opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//  mem_ready    in   1   memory read data valid on Mdatain this cycle
//  pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in  out 1  datapath strobes
//  z_high_in, z_low_in, z_high_out, z_low_out, hi_in, lo_in    out 1  datapath strobes
//  alu_op       out  5   ALU opcode (= ir[31:27] in T4, else 5'b0)
//  r_out        out  16  one-hot general-register bus-drive select
//  r_in         out  16  one-hot general-register load select
//  busy         out  1   high in every state except IDLE and HALT
//  done         out  1   one-cycle pulse in the final step of each instruction
//  illegal_op   out  1   high while in HALT because of an unsupported opcode
//  mem_fault    out  1   high while in HALT because of a timeout (CS_MEM_TIMEOUT_EN only; tied 0 otherwise)
// BEHAVIOUR
//  - All outputs are a pure decode of the registered state and IR fields.
//  - IDLE decodes every output to 0.
//  - clear=0 at any rising edge: state <= IDLE, timeout counter <= 0. Outputs are 0 the next cycle, including mid-instruction.
//  - States and their outputs:
//      IDLE -> T0 when run=1.
//      T0: pc_out, mar_in, inc_pc.
//      T1: read, mdr_in. Stays in T1 until mem_ready=1.
//      T2: mdr_out, ir_in.
//      T3 (decode, IR now valid): r_out[Rb], y_in.
//      T4: r_out[Rc] (r_out[Rb] for neg/not), alu_op=opcode, z_low_in. z_high_in also for mul/div.
//      T5: z_low_out. Loads r_in[Ra] for ALU ops, lo_in for mul/div.
//      T6 (mul/div only): z_high_out, hi_in.
//  - Supported opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011,
//    div 01111, mul 10000, neg 10001, not 10010.
//  - Any other opcode in T3: no strobes at all (r_out=0, y_in=0). Next state is HALT.
//  - HALT: illegal_op=1, all strobes 0, exit only by reset.
//  - done=1 in T5 (ALU ops) or T6 (mul/div). Next state is T0 if run=1, else IDLE.
//  - Latency with mem_ready=1 in the first T1 cycle: ALU op 6 cycles, mul/div 7 cycles. Each T1 wait cycle adds 1.
//  - run falling mid-instruction has no effect; the instruction completes.
//  - r_in and r_out are never both nonzero in the same state. At most one bit of each is set.
//  - mem_ready outside T1 is ignored.
// CONFIGURATION
//  - CS_MEM_TIMEOUT_EN defined: a 4-bit+ counter counts cycles spent in T1 and clears on leaving T1.
//    If MEM_TIMEOUT cycles elapse without mem_ready: next state is HALT with mem_fault=1 and no write to MDR.
//  - CS_MEM_TIMEOUT_EN undefined: T1 waits indefinitely, no counter exists, mem_fault tied 0.
// STRUCTURE
//  - Shared package cpu_pkg: opcode localparams (OP_ADD..OP_NOT), state encoding (ST_IDLE, ST_T0..ST_T6, ST_HALT),
//    and IR field bit positions.
//  - Sub-module sel_decode_4to16 (en, sel[3:0] -> onehot[15:0]), instantiated twice: Ra->r_in and Rb/Rc->r_out.
// TESTING
//  1. Reset low 2 cycles, run=1, ir=add R1,R2,R3 (0x18918000), mem_ready=1:
//     T0..T5 in 6 cycles; r_out=0x0004 in T3, r_out=0x0008 with alu_op=00011 in T4,
//     r_in=0x0002 with done=1 in T5.
//  2. mul R0,R4,R5 (Rb=4, Rc=5): z_high_in=z_low_in=1 in T4, lo_in in T5, hi_in with done in T6, r_in=0 throughout.
//  3. mem_ready held low 4 cycles: T1 lasts 5 cycles, read=mdr_in=1 each cycle; instruction total 10 cycles.
//  4. Opcode 11111: T3 drives no strobes, then HALT with illegal_op=1 and busy=0.
//     run toggled afterwards: remains in HALT until clear=0.
//  5. clear=0 in T4: next cycle all outputs 0, state IDLE.
//     run=1 then restarts at T0 with pc_out=1.
//  6. With CS_MEM_TIMEOUT_EN and MEM_TIMEOUT=15, mem_ready=0: mem_fault=1 after 15 T1 cycles.
//     Without the macro: still in T1 after 100 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer and its decoders:
// opcodes, IR field positions, FSM state encoding and the strobe bundle.
package cpu_pkg;

   typedef logic [4:0] opcode_t;

   // Supported opcodes
   localparam opcode_t OP_ADD  = 5'b00011;
   localparam opcode_t OP_SUB  = 5'b00100;
   localparam opcode_t OP_AND  = 5'b00101;
   localparam opcode_t OP_OR   = 5'b00110;
   localparam opcode_t OP_ROR  = 5'b00111;
   localparam opcode_t OP_ROL  = 5'b01000;
   localparam opcode_t OP_SHR  = 5'b01001;
   localparam opcode_t OP_SHRA = 5'b01010;
   localparam opcode_t OP_SHL  = 5'b01011;
   localparam opcode_t OP_DIV  = 5'b01111;
   localparam opcode_t OP_MUL  = 5'b10000;
   localparam opcode_t OP_NEG  = 5'b10001;
   localparam opcode_t OP_NOT  = 5'b10010;

   // IR field bit positions
   localparam int IR_OP_MSB = 31;
   localparam int IR_OP_LSB = 27;
   localparam int IR_RA_MSB = 26;
   localparam int IR_RA_LSB = 23;
   localparam int IR_RB_MSB = 22;
   localparam int IR_RB_LSB = 19;
   localparam int IR_RC_MSB = 18;
   localparam int IR_RC_LSB = 15;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_HALT
   } state_t;

   // Single-bit datapath strobes, decoded together from the state
   typedef struct packed {
      logic pc_out;
      logic mar_in;
      logic inc_pc;
      logic read;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic y_in;
      logic z_high_in;
      logic z_low_in;
      logic z_high_out;
      logic z_low_out;
      logic hi_in;
      logic lo_in;
   } strobes_t;

   function automatic logic op_is_muldiv(input opcode_t op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   // neg/not take their only operand from Rb in both T3 and T4
   function automatic logic op_is_unary(input opcode_t op);
      return (op == OP_NEG) || (op == OP_NOT);
   endfunction

   function automatic logic op_is_legal(input opcode_t op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
                        OP_SHRA, OP_SHL, OP_DIV, OP_MUL, OP_NEG, OP_NOT};
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between the control sequencer (master)
// and the datapath it drives (slave).
interface control_sequencer_if;
   import cpu_pkg::*;

   logic        run;
   logic [31:0] ir;
   logic        mem_ready;

   logic        pc_out;
   logic        mar_in;
   logic        inc_pc;
   logic        read;
   logic        mdr_in;
   logic        mdr_out;
   logic        ir_in;
   logic        y_in;
   logic        z_high_in;
   logic        z_low_in;
   logic        z_high_out;
   logic        z_low_out;
   logic        hi_in;
   logic        lo_in;
   opcode_t     alu_op;
   logic [15:0] r_out;
   logic [15:0] r_in;
   logic        busy;
   logic        done;
   logic        illegal_op;
   logic        mem_fault;

   modport master (
      input  run, ir, mem_ready,
      output pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in,
             z_high_in, z_low_in, z_high_out, z_low_out, hi_in, lo_in,
             alu_op, r_out, r_in, busy, done, illegal_op, mem_fault
   );

   modport slave (
      output run, ir, mem_ready,
      input  pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in,
             z_high_in, z_low_in, z_high_out, z_low_out, hi_in, lo_in,
             alu_op, r_out, r_in, busy, done, illegal_op, mem_fault
   );

endinterface

// File: rtl/sel_decode_4to16.sv
// 4-to-16 one-hot decoder with enable; output is all-zero when disabled.
module sel_decode_4to16 (
   input  logic        en,
   input  logic [3:0]  sel,
   output logic [15:0] onehot
);

   assign onehot = en ? (16'h0001 << sel) : 16'h0000;

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (with memory-ready handshake), decode and
// execute for register-register ALU, unary and mul/div instructions.
// Optional feature macro: CS_MEM_TIMEOUT_EN -- bounds the T1 wait to
// MEM_TIMEOUT cycles and halts with mem_fault when it expires.
module control_sequencer
   import cpu_pkg::*;
`ifdef CS_MEM_TIMEOUT_EN
   #(parameter int unsigned MEM_TIMEOUT = 15)
`endif
   (
   input  logic                clock,
   input  logic                clear,
   control_sequencer_if.master bus
);

   state_t   state;
   opcode_t  op;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] rc;
   logic     is_legal;
   logic     is_muldiv;
   logic     is_unary;
   logic     unused_ir_low;

   assign op        = bus.ir[IR_OP_MSB:IR_OP_LSB];
   assign ra        = bus.ir[IR_RA_MSB:IR_RA_LSB];
   assign rb        = bus.ir[IR_RB_MSB:IR_RB_LSB];
   assign rc        = bus.ir[IR_RC_MSB:IR_RC_LSB];
   assign is_legal  = op_is_legal(op);
   assign is_muldiv = op_is_muldiv(op);
   assign is_unary  = op_is_unary(op);

   // Low IR bits carry immediates for other instruction classes.
   assign unused_ir_low = ^bus.ir[IR_RC_LSB-1:0];

`ifdef CS_MEM_TIMEOUT_EN
   localparam int unsigned CNT_W =
      ($clog2(MEM_TIMEOUT + 1) < 4) ? 4 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] t1_cnt;
   logic             halt_fault;
`endif

   // State register, T1 wait counter and halt-reason flag
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!clear) begin
         state <= ST_IDLE;
`ifdef CS_MEM_TIMEOUT_EN
         t1_cnt     <= '0;
         halt_fault <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (bus.run) state <= ST_T0;
            ST_T0:   state <= ST_T1;
`ifdef CS_MEM_TIMEOUT_EN
            ST_T1: begin
               if (bus.mem_ready) begin
                  state  <= ST_T2;
                  t1_cnt <= '0;
               end else if (t1_cnt == CNT_LAST) begin
                  state      <= ST_HALT;
                  halt_fault <= 1'b1;
                  t1_cnt     <= '0;
               end else begin
                  t1_cnt <= t1_cnt + 1'b1;
               end
            end
`else
            ST_T1:   if (bus.mem_ready) state <= ST_T2;
`endif
            ST_T2:   state <= ST_T3;
            ST_T3:   state <= is_legal ? ST_T4 : ST_HALT;
            ST_T4:   state <= ST_T5;
            ST_T5: begin
               if (is_muldiv)    state <= ST_T6;
               else if (bus.run) state <= ST_T0;
               else              state <= ST_IDLE;
            end
            ST_T6:   state <= bus.run ? ST_T0 : ST_IDLE;
            ST_HALT: state <= ST_HALT;
            default: state <= ST_IDLE;
         endcase
      end
   end

   strobes_t   stb;
   logic       rout_en;
   logic [3:0] rout_sel;
   logic       rin_en;

   // Strobe and register-select decode from the current state and IR
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      stb      = '0;
      rout_en  = 1'b0;
      rout_sel = rb;
      rin_en   = 1'b0;
      case (state)
         ST_T0: begin
            stb.pc_out = 1'b1;
            stb.mar_in = 1'b1;
            stb.inc_pc = 1'b1;
         end
         ST_T1: begin
            stb.read   = 1'b1;
            stb.mdr_in = 1'b1;
         end
         ST_T2: begin
            stb.mdr_out = 1'b1;
            stb.ir_in   = 1'b1;
         end
         ST_T3: begin
            // An unsupported opcode drives nothing on its way to HALT
            rout_en  = is_legal;
            stb.y_in = is_legal;
         end
         ST_T4: begin
            rout_en       = 1'b1;
            rout_sel      = is_unary ? rb : rc;
            stb.z_low_in  = 1'b1;
            stb.z_high_in = is_muldiv;
         end
         ST_T5: begin
            stb.z_low_out = 1'b1;
            stb.lo_in     = is_muldiv;
            rin_en        = !is_muldiv;
         end
         ST_T6: begin
            stb.z_high_out = 1'b1;
            stb.hi_in      = 1'b1;
         end
         default: ;
      endcase
   end

   sel_decode_4to16 u_rin_dec (
      .en     (rin_en),
      .sel    (ra),
      .onehot (bus.r_in)
   );

   sel_decode_4to16 u_rout_dec (
      .en     (rout_en),
      .sel    (rout_sel),
      .onehot (bus.r_out)
   );

   assign bus.pc_out     = stb.pc_out;
   assign bus.mar_in     = stb.mar_in;
   assign bus.inc_pc     = stb.inc_pc;
   assign bus.read       = stb.read;
   assign bus.mdr_in     = stb.mdr_in;
   assign bus.mdr_out    = stb.mdr_out;
   assign bus.ir_in      = stb.ir_in;
   assign bus.y_in       = stb.y_in;
   assign bus.z_high_in  = stb.z_high_in;
   assign bus.z_low_in   = stb.z_low_in;
   assign bus.z_high_out = stb.z_high_out;
   assign bus.z_low_out  = stb.z_low_out;
   assign bus.hi_in      = stb.hi_in;
   assign bus.lo_in      = stb.lo_in;

   assign bus.alu_op = (state == ST_T4) ? op : 5'b00000;
   assign bus.busy   = (state != ST_IDLE) && (state != ST_HALT);
   assign bus.done   = ((state == ST_T5) && !is_muldiv) || (state == ST_T6);

`ifdef CS_MEM_TIMEOUT_EN
   assign bus.illegal_op = (state == ST_HALT) && !halt_fault;
   assign bus.mem_fault  = (state == ST_HALT) && halt_fault;
`else
   assign bus.illegal_op = (state == ST_HALT);
   assign bus.mem_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a queue of per-cycle expected
// outputs and input drives is built from the instruction step table, then
// replayed against the DUT one clock at a time.
module tb_control_sequencer;

   localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101,
                          OR_ = 5'b00110, ROR = 5'b00111, ROL = 5'b01000,
                          SHR = 5'b01001, SHRA = 5'b01010, SHL = 5'b01011,
                          DIV = 5'b01111, MUL = 5'b10000, NEG = 5'b10001,
                          NOT_ = 5'b10010;

   localparam logic [4:0] LEGAL_OPS [13] = '{ADD, SUB, AND_, OR_, ROR, ROL, SHR,
                                             SHRA, SHL, DIV, MUL, NEG, NOT_};

   typedef struct packed {
      logic        pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in;
      logic        z_high_in, z_low_in, z_high_out, z_low_out, hi_in, lo_in;
      logic [4:0]  alu_op;
      logic [15:0] r_out;
      logic [15:0] r_in;
      logic        busy, done, illegal_op, mem_fault;
   } obs_t;

   typedef struct {
      string       tag;
      obs_t        exp;
      logic        clr;
      logic        run;
      logic        mr;
      logic [31:0] ir;
   } item_t;

   logic clock = 1'b0;
   logic clear;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   item_t q[$];

   always #5 clock = ~clock;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   task automatic check(input string tag, input obs_t got, input obs_t exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.pc_out     = bus.pc_out;
      o.mar_in     = bus.mar_in;
      o.inc_pc     = bus.inc_pc;
      o.read       = bus.read;
      o.mdr_in     = bus.mdr_in;
      o.mdr_out    = bus.mdr_out;
      o.ir_in      = bus.ir_in;
      o.y_in       = bus.y_in;
      o.z_high_in  = bus.z_high_in;
      o.z_low_in   = bus.z_low_in;
      o.z_high_out = bus.z_high_out;
      o.z_low_out  = bus.z_low_out;
      o.hi_in      = bus.hi_in;
      o.lo_in      = bus.lo_in;
      o.alu_op     = bus.alu_op;
      o.r_out      = bus.r_out;
      o.r_in       = bus.r_in;
      o.busy       = bus.busy;
      o.done       = bus.done;
      o.illegal_op = bus.illegal_op;
      o.mem_fault  = bus.mem_fault;
      return o;
   endfunction

   function automatic logic rbit();
      return ($urandom_range(0, 1) == 1);
   endfunction

   function automatic logic legal(input logic [4:0] op);
      foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic obs_t exp_busy();
      obs_t e = '0;
      e.busy = 1'b1;
      return e;
   endfunction

   function automatic obs_t exp_t0();
      obs_t e = exp_busy();
      e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1;
      return e;
   endfunction

   function automatic obs_t exp_t1();
      obs_t e = exp_busy();
      e.read = 1'b1; e.mdr_in = 1'b1;
      return e;
   endfunction

   task automatic push(input string tag, input obs_t e, input logic clr,
                       input logic run, input logic mr, input logic [31:0] ir);
      item_t it;
      it.tag = tag; it.exp = e; it.clr = clr; it.run = run; it.mr = mr; it.ir = ir;
      q.push_back(it);
   endtask

   // n idle cycles; the last one raises run when start is set
   task automatic push_idle(input int n, input logic start);
      for (int i = 0; i < n; i++)
         push("IDLE", '0, 1'b1, (i == n - 1) ? start : 1'b0, rbit(), $urandom);
   endtask

   // n cycles parked in HALT with run toggling; the last one asserts clear
   task automatic push_halt(input logic fault, input int n);
      obs_t e;
      for (int i = 0; i < n; i++) begin
         e = '0;
         if (fault) e.mem_fault = 1'b1;
         else       e.illegal_op = 1'b1;
         push("HALT", e, (i == n - 1) ? 1'b0 : 1'b1, (i % 2) == 1, rbit(), $urandom);
      end
   endtask

   // One instruction; must be entered with run already requested. The item
   // after it is an idle cycle unless cont is set and it completes normally.
   task automatic push_instr(input logic [31:0] instr, input int waits,
                             input logic cont, input logic clr_t4);
      logic [4:0] op = instr[31:27];
      logic [3:0] ra = instr[26:23];
      logic [3:0] rb = instr[22:19];
      logic [3:0] rc = instr[18:15];
      logic md = (op == MUL) || (op == DIV);
      logic un = (op == NEG) || (op == NOT_);
      obs_t e;
      push("T0", exp_t0(), 1'b1, rbit(), rbit(), $urandom);
      for (int i = 0; i <= waits; i++)
         push("T1", exp_t1(), 1'b1, rbit(), (i == waits), $urandom);
      e = exp_busy(); e.mdr_out = 1'b1; e.ir_in = 1'b1;
      push("T2", e, 1'b1, rbit(), rbit(), instr);
      e = exp_busy();
      if (legal(op)) begin
         e.r_out = 16'h0001 << rb;
         e.y_in  = 1'b1;
      end
      push("T3", e, 1'b1, rbit(), rbit(), instr);
      if (!legal(op)) begin
         push_halt(1'b0, 2 + $urandom_range(0, 2));
         push_idle(1, cont);
         return;
      end
      e = exp_busy();
      e.r_out = 16'h0001 << (un ? rb : rc);
      e.alu_op = op; e.z_low_in = 1'b1; e.z_high_in = md;
      push("T4", e, !clr_t4, rbit(), rbit(), instr);
      if (clr_t4) begin
         push_idle(1, cont);
         return;
      end
      e = exp_busy(); e.z_low_out = 1'b1;
      if (md) e.lo_in = 1'b1;
      else begin
         e.r_in = 16'h0001 << ra;
         e.done = 1'b1;
      end
      push("T5", e, 1'b1, md ? rbit() : cont, rbit(), instr);
      if (md) begin
         e = exp_busy(); e.z_high_out = 1'b1; e.hi_in = 1'b1; e.done = 1'b1;
         push("T6", e, 1'b1, cont, rbit(), instr);
      end
   endtask

   function automatic logic [31:0] make_instr(input logic [4:0] op);
      return {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
   endfunction

   initial begin
      logic [4:0] op;
      logic       cont;
      item_t      it;

      clear         = 1'b0;
      bus.run       = 1'b0;
      bus.mem_ready = 1'b0;
      bus.ir        = '0;

      // Reset state, then add R1,R2,R3
      push("RESET", '0, 1'b1, 1'b1, 1'b0, 32'h0);
      push_instr(32'h18918000, 0, 1'b0, 1'b0);
      push_idle(2, 1'b1);
      // mul R0,R4,R5 followed back-to-back by sub with four T1 wait cycles
      push_instr(32'h80228000, 0, 1'b1, 1'b0);
      push_instr(make_instr(SUB), 4, 1'b0, 1'b0);
      push_idle(1, 1'b1);
      // clear in T4, then restart
      push_instr(make_instr(AND_), 0, 1'b1, 1'b1);
      push_instr(make_instr(OR_), 1, 1'b0, 1'b0);
      push_idle(1, 1'b1);

      // Random mix, mostly legal opcodes
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            do op = 5'($urandom); while (legal(op));
         end else begin
            op = LEGAL_OPS[$urandom_range(0, 12)];
         end
         cont = rbit();
         push_instr(make_instr(op), $urandom_range(0, 3), cont, 1'b0);
         if (!cont) push_idle($urandom_range(1, 3), 1'b1);
      end

      // Opcode 11111 halts; run toggling must not leave HALT
      push_instr({5'b11111, 27'($urandom)}, 0, 1'b1, 1'b0);

      // Memory never ready
      push("T0", exp_t0(), 1'b1, rbit(), rbit(), $urandom);
`ifdef CS_MEM_TIMEOUT_EN
      for (int i = 0; i < 15; i++)
         push("T1_wait", exp_t1(), 1'b1, rbit(), 1'b0, $urandom);
      push_halt(1'b1, 3);
`else
      for (int i = 0; i < 100; i++)
         push("T1_wait", exp_t1(), (i == 99) ? 1'b0 : 1'b1, rbit(), 1'b0, $urandom);
`endif
      push_idle(2, 1'b0);

      repeat (2) @(posedge clock);
      while (q.size() > 0) begin
         it = q.pop_front();
         @(negedge clock);
         cyc++;
         check($sformatf("%s@%0d", it.tag, cyc), sample(), it.exp);
         clear         = it.clr;
         bus.run       = it.run;
         bus.mem_ready = it.mr;
         bus.ir        = it.ir;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
